// File: rtl/deserializador.sv
// deserializador: serial-to-byte converter that aligns on SYNC_BYTE; define SYNC_STRIP_EN to drop in-stream sync bytes
module deserializador #(
   parameter logic [7:0] SYNC_BYTE  = 8'hBC,
   parameter int         IDLE_LIMIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   input  logic       DK,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       locked
);
   localparam logic [0:0] SEARCH = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;
   localparam int IW = $clog2(IDLE_LIMIT + 1);
   logic [0:0]    state;
   logic [7:0]    shreg;
   logic [7:0]    shreg_nx;
   logic [3:0]    fill;
   logic [3:0]    fill_nx;
   logic [2:0]    bit_cnt;
   logic [IW-1:0] idle;
   logic          match;
   logic          byte_done;
   logic          idle_out;
   logic          deliver;
   // Next-sample views and the events they trigger this edge
   always_comb begin
      shreg_nx  = {shreg[6:0], in};
      fill_nx   = (fill == 4'd8) ? 4'd8 : fill + 4'd1;
      match     = DK && state == SEARCH && shreg_nx == SYNC_BYTE && fill_nx == 4'd8;
      byte_done = DK && state == LOCKED && bit_cnt == 3'd7;
      idle_out  = !DK && state == LOCKED && idle == IW'(IDLE_LIMIT - 1);
`ifdef SYNC_STRIP_EN
      deliver   = byte_done && shreg_nx != SYNC_BYTE;
`else
      deliver   = byte_done;
`endif
   end
   // Shift register and search fill counter; an idle timeout discards the partial byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
         fill  <= '0;
      end else if (idle_out) begin
         shreg <= '0;
         fill  <= '0;
      end else if (DK) begin
         shreg <= shreg_nx;
         if (state == SEARCH) fill <= fill_nx;
      end
   end
   // Alignment FSM with byte-position and idle counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= SEARCH;
         bit_cnt <= '0;
         idle    <= '0;
      end else if (match) begin
         state   <= LOCKED;
         bit_cnt <= '0;
         idle    <= '0;
      end else if (idle_out) begin
         state   <= SEARCH;
         bit_cnt <= '0;
         idle    <= '0;
      end else if (state == LOCKED) begin
         bit_cnt <= DK ? bit_cnt + 3'd1 : bit_cnt;
         idle    <= DK ? '0 : idle + IW'(1);
      end
   end
   // Byte output register; data holds between strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= deliver;
         if (deliver) data_out <= shreg_nx;
      end
   end
   assign locked = (state == LOCKED);
endmodule

// File: tb/tb_deserializador.sv
// tb_deserializador: randomized and directed checks of deserializador against a queue-based reference model; honours SYNC_STRIP_EN
module tb_deserializador;
   localparam logic [7:0] SYNC = 8'hBC;
   localparam int IDLE = 16;
`ifdef SYNC_STRIP_EN
   localparam bit STRIP = 1'b1;
`else
   localparam bit STRIP = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst;
   logic       in;
   logic       DK;
   logic [7:0] data_out;
   logic       valid_out;
   logic       locked;
   int total = 0;
   int bad = 0;
   // reference model: bits seen since entering the current mode
   bit         hist[$];
   bit         m_locked;
   int         m_idle;
   logic [7:0] m_data;
   bit         m_valid;

   deserializador dut (
      .clk(clk), .rst(rst), .in(in), .DK(DK),
      .data_out(data_out), .valid_out(valid_out), .locked(locked)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pack();
      logic [7:0] v = 8'h00;
      foreach (hist[i]) v = {v[6:0], hist[i]};
      return v;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_locked = 0;
      m_idle = 0;
      m_data = 8'h00;
      m_valid = 0;
   endtask

   task automatic model_edge(input bit b, input bit dk);
      logic [7:0] v;
      m_valid = 0;
      if (!m_locked) begin
         if (dk) begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            if (hist.size() == 8 && pack() == SYNC) begin
               m_locked = 1;
               m_idle = 0;
               hist.delete();
            end
         end
      end else if (dk) begin
         m_idle = 0;
         hist.push_back(b);
         if (hist.size() == 8) begin
            v = pack();
            hist.delete();
            if (!(STRIP && v == SYNC)) begin
               m_valid = 1;
               m_data = v;
            end
         end
      end else begin
         m_idle++;
         if (m_idle == IDLE) begin
            m_locked = 0;
            m_idle = 0;
            hist.delete();
         end
      end
   endtask

   task automatic step(input logic b, input logic dk);
      in = b;
      DK = dk;
      @(posedge clk);
      model_edge(b, dk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v, output int nv);
      nv = 0;
      for (int i = 7; i >= 0; i--) begin
         step(v[i], 1'b1);
         if (valid_out) nv++;
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in = 1'b0;
      DK = 1'b0;
      model_reset();
      #12;
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b0);
   endtask

   task automatic test_lock();
      logic [7:0] v = SYNC;
      int nv = 0;
      for (int i = 7; i >= 0; i--) begin
         step(v[i], 1'b1);
         if (valid_out) nv++;
         if (i == 1) begin
            total++; if (locked !== 1'b0) begin bad++; $display("FAIL early_lock: got %b want 0", locked); end
         end
      end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_8th: got %b want 1", locked); end
      total++; if (nv !== 0) begin bad++; $display("FAIL sync_no_strobe: got %0d want 0", nv); end
      v = 8'h5A;
      for (int i = 7; i >= 0; i--) begin
         step(v[i], 1'b1);
         if (valid_out) nv++;
      end
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL lock_valid16: got %b want 1", valid_out); end
      total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL lock_data: got %h want 5a", data_out); end
      total++; if (nv !== 1) begin bad++; $display("FAIL lock_strobes: got %0d want 1", nv); end
   endtask

   task automatic test_dk_gap();
      logic [7:0] v = 8'hA5;
      int nv = 0;
      for (int i = 7; i >= 0; i--) begin
         step(v[i], 1'b1);
         if (valid_out) nv++;
         if (i == 4) for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            if (valid_out) nv++;
         end
      end
      total++; if (nv !== 1) begin bad++; $display("FAIL gap_strobes: got %0d want 1", nv); end
      total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL gap_data: got %h want a5", data_out); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL gap_locked: got %b want 1", locked); end
   endtask

   task automatic test_idle_drop();
      int nv = 0;
      int nb;
      for (int i = 0; i < IDLE; i++) begin
         step(1'b0, 1'b0);
         if (valid_out) nv++;
         if (i == IDLE - 2) begin
            total++; if (locked !== 1'b1) begin bad++; $display("FAIL idle_early_drop: got %b want 1", locked); end
         end
      end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL idle_drop: got %b want 0", locked); end
      total++; if (nv !== 0) begin bad++; $display("FAIL idle_strobes: got %0d want 0", nv); end
      send_byte(8'h33, nb);
      total++; if (nb !== 0) begin bad++; $display("FAIL post_drop_strobes: got %0d want 0", nb); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL post_drop_locked: got %b want 0", locked); end
   endtask

   task automatic test_sync_strip();
      int nv;
      logic [7:0] prev;
      send_byte(SYNC, nv);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock: got %b want 1", locked); end
      prev = m_data;
      send_byte(SYNC, nv);
      total++; if (nv !== (STRIP ? 0 : 1)) begin bad++; $display("FAIL strip_strobes: got %0d want %0d", nv, STRIP ? 0 : 1); end
      total++; if (data_out !== (STRIP ? prev : SYNC)) begin bad++; $display("FAIL strip_data: got %h want %h", data_out, STRIP ? prev : SYNC); end
      send_byte(8'h01, nv);
      total++; if (nv !== 1) begin bad++; $display("FAIL strip_next_strobes: got %0d want 1", nv); end
      total++; if (data_out !== 8'h01) begin bad++; $display("FAIL strip_next_data: got %h want 01", data_out); end
   endtask

   task automatic test_reset_mid_byte();
      logic [7:0] v = 8'hE7;
      int nv;
      for (int i = 7; i >= 3; i--) step(v[i], 1'b1);
      #2;
      rst = 1'b0;
      #1;
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL async_data: got %h want 00", data_out); end
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", valid_out); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL async_locked: got %b want 0", locked); end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      send_byte(8'h77, nv);
      total++; if (nv !== 0) begin bad++; $display("FAIL post_reset_strobes: got %0d want 0", nv); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL post_reset_locked: got %b want 0", locked); end
   endtask

   task automatic test_junk_align();
      logic [7:0] v = SYNC;
      int nv;
      pulse_reset();
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         step(v[i], 1'b1);
         if (i == 1) begin
            total++; if (locked !== 1'b0) begin bad++; $display("FAIL junk_early_lock: got %b want 0", locked); end
         end
      end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL junk_lock: got %b want 1", locked); end
      send_byte(8'hC3, nv);
      total++; if (nv !== 1) begin bad++; $display("FAIL junk_strobes: got %0d want 1", nv); end
      total++; if (data_out !== 8'hC3) begin bad++; $display("FAIL junk_data: got %h want c3", data_out); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      for (int k = 0; k < 4; k++) begin
         v = 8'($urandom_range(0, 255));
         if (STRIP && v == SYNC) v = 8'h42;
         for (int i = 7; i >= 0; i--) begin
            step(v[i], 1'b1);
            total++; if (valid_out !== (i == 0)) begin bad++; $display("FAIL b2b_valid: byte %0d bit %0d got %b want %b", k, i, valid_out, i == 0); end
         end
         total++; if (data_out !== v) begin bad++; $display("FAIL b2b_data: byte %0d got %h want %h", k, data_out, v); end
      end
   endtask

   task automatic test_random();
      bit cb[$];
      bit cd[$];
      logic [7:0] v;
      pulse_reset();
      for (int k = 0; k < 300; k++) begin
         v = ($urandom_range(0, 2) == 0) ? SYNC : 8'($urandom_range(0, 255));
         for (int i = 7; i >= 0; i--) begin
            while ($urandom_range(0, 7) == 0) begin cb.push_back(1'($urandom_range(0, 1))); cd.push_back(1'b0); end
            cb.push_back(v[i]);
            cd.push_back(1'b1);
         end
         if ($urandom_range(0, 14) == 0) begin
            for (int j = $urandom_range(10, 20); j > 0; j--) begin cb.push_back(1'b0); cd.push_back(1'b0); end
         end
         if ($urandom_range(0, 20) == 0) begin cb.push_back(1'($urandom_range(0, 1))); cd.push_back(1'b1); end
      end
      foreach (cb[n]) begin
         step(cb[n], cd[n]);
         total++; if (valid_out !== m_valid) begin bad++; $display("FAIL rand_valid: cycle %0d got %b want %b", n, valid_out, m_valid); end
         total++; if (data_out !== m_data) begin bad++; $display("FAIL rand_data: cycle %0d got %h want %h", n, data_out, m_data); end
         total++; if (locked !== m_locked) begin bad++; $display("FAIL rand_locked: cycle %0d got %b want %b", n, locked, m_locked); end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_dk_gap();
      test_idle_drop();
      test_sync_strip();
      test_reset_mid_byte();
      test_junk_align();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
